// File: rtl/fifo_pkg.sv
// Shared helpers for the multi-lane FIFO family: lane-mask population count
// and the occupancy-width derivation.
package fifo_pkg;

  // Widest read mask popcount_nrd accepts; lane counts above this are not supported.
  localparam int MAX_LANES = 32;

  function automatic int cnt_width(input int depth, input int num_rd);
    return $clog2(depth + num_rd + 1);
  endfunction

  function automatic int popcount_nrd(input logic [MAX_LANES-1:0] mask);
    int n;
    n = 0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (mask[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/fifo_lane_compact.sv
// Combinational lane compactor: removes read lanes and packs the surviving
// valid lanes toward lane 0 in their original order.
module fifo_lane_compact #(
  parameter  int WIDTH  = 8,
  parameter  int NUM_RD = 4,
  localparam int SURV_W = $clog2(NUM_RD + 1)
) (
  input  logic [NUM_RD-1:0] valid,
  input  logic [WIDTH-1:0]  data [NUM_RD-1:0],
  input  logic [NUM_RD-1:0] rd,
  output logic [NUM_RD-1:0] valid_c,
  output logic [WIDTH-1:0]  data_c [NUM_RD-1:0],
  output logic [SURV_W-1:0] survivors
);

  logic [NUM_RD-1:0] keep;

  assign keep = valid & ~rd;

  // NOTE: every output gets a default before the loops so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    int pos;
    valid_c = '0;
    for (int k = 0; k < NUM_RD; k++) data_c[k] = '0;
    pos = 0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (keep[i]) begin
        for (int k = 0; k < NUM_RD; k++) begin
          if (pos == k) begin
            valid_c[k] = 1'b1;
            data_c[k]  = data[i];
          end
        end
        pos++;
      end
    end
    survivors = SURV_W'(pos);
  end

endmodule

// File: rtl/fifo_w1rn.sv
// Single-write, NUM_RD-lane read FIFO. Lanes hold the oldest entries; the
// backing memory holds the rest, and writes bypass memory when a lane is free.
module fifo_w1rn
  import fifo_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 8,
  parameter  int NUM_RD = 4,
  localparam int CNT_W  = cnt_width(DEPTH, NUM_RD)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  output logic              ready_in,
  input  logic              valid_in,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [NUM_RD-1:0] ready_out,
  output logic [NUM_RD-1:0] valid_out,
  output logic [WIDTH-1:0]  data_out [NUM_RD-1:0],
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int MCNT_W = $clog2(DEPTH + 1);
  localparam int SURV_W = $clog2(NUM_RD + 1);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [MCNT_W-1:0] mem_count, mem_count_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic [NUM_RD-1:0] rd_mask, cvalid, lane_valid_nxt;
  logic [WIDTH-1:0]  cdata [NUM_RD-1:0];
  logic [WIDTH-1:0]  lane_data_nxt [NUM_RD-1:0];
  logic [SURV_W-1:0] survivors;
  logic              wr_fire, bypass, mem_we;

  assign ready_in = int'(mem_count) < DEPTH;
  assign wr_fire  = valid_in && ready_in;
  assign rd_mask  = valid_out & ready_out;

  fifo_lane_compact #(.WIDTH(WIDTH), .NUM_RD(NUM_RD)) u_compact (
    .valid     (valid_out),
    .data      (data_out),
    .rd        (rd_mask),
    .valid_c   (cvalid),
    .data_c    (cdata),
    .survivors (survivors)
  );

  always_comb begin
    int n_surv, n_fill, slot, idx, rp;
    n_surv = int'(survivors);
    n_fill = NUM_RD - n_surv;
    if (n_fill > int'(mem_count)) n_fill = int'(mem_count);
    slot   = n_surv + n_fill;
    bypass = wr_fire && (slot < NUM_RD);
    mem_we = wr_fire && !bypass;

    lane_valid_nxt = '0;
    for (int k = 0; k < NUM_RD; k++) lane_data_nxt[k] = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      // Memory offset for the lane; only meaningful in the fill range.
      idx = int'(rd_ptr) + k - n_surv;
      if (idx >= DEPTH) idx -= DEPTH;
      if (cvalid[k]) begin
        lane_valid_nxt[k] = 1'b1;
        lane_data_nxt[k]  = cdata[k];
      end else if (k < slot) begin
        lane_valid_nxt[k] = 1'b1;
        lane_data_nxt[k]  = mem[PTR_W'(idx)];
      end else if (k == slot && bypass) begin
        lane_valid_nxt[k] = 1'b1;
        lane_data_nxt[k]  = data_in;
      end
    end

    rp = int'(rd_ptr) + n_fill;
    if (rp >= DEPTH) rp -= DEPTH;
    rd_ptr_nxt = PTR_W'(rp);
    if (mem_we) wr_ptr_nxt = (int'(wr_ptr) == DEPTH - 1) ? '0 : wr_ptr + 1'b1;
    else        wr_ptr_nxt = wr_ptr;

    mem_count_nxt = MCNT_W'(int'(mem_count) - n_fill + int'(mem_we));
    count_nxt     = CNT_W'(int'(count) + int'(wr_fire) - popcount_nrd(MAX_LANES'(rd_mask)));
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_out <= '0;
      for (int k = 0; k < NUM_RD; k++) data_out[k] <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      mem_count <= '0;
      count     <= '0;
    end else begin
      valid_out <= lane_valid_nxt;
      for (int k = 0; k < NUM_RD; k++) data_out[k] <= lane_data_nxt[k];
      rd_ptr    <= rd_ptr_nxt;
      wr_ptr    <= wr_ptr_nxt;
      mem_count <= mem_count_nxt;
      count     <= count_nxt;
    end
  end

  // NOTE: the storage array has no reset; mem_count gates every read, so
  // stale contents are never observed and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we && !reset && !flush) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_count_cap : assert (int'(count) <= DEPTH + NUM_RD);
      a_lane_contig : assert (((valid_out + NUM_RD'(1)) & valid_out) == '0);
      a_count_sum : assert (int'(count) ==
                            int'(mem_count) + popcount_nrd(MAX_LANES'(valid_out)));
    end
  end

endmodule

// File: tb/tb_fifo_w1rn.sv
// Bench for fifo_w1rn: two instances (DEPTH 8 and 5) share stimulus and are
// compared every cycle against an ordered-queue model of the FIFO.
module tb_fifo_w1rn;

  localparam int NRD  = 4;
  localparam int CAP8 = 8 + NRD;
  localparam int CAP5 = 5 + NRD;

  typedef logic [7:0] byteq_t [$];

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           flush = 1'b0;
  logic           valid_in = 1'b0;
  logic [7:0]     data_in = '0;
  logic [NRD-1:0] ready_out = '0;

  logic           rdy8, rdy5;
  logic [NRD-1:0] v8, v5;
  logic [7:0]     d8 [NRD-1:0];
  logic [7:0]     d5 [NRD-1:0];
  logic [3:0]     c8, c5;

  byteq_t q8, q5;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_w1rn #(.WIDTH(8), .DEPTH(8), .NUM_RD(NRD)) u_dut8 (
    .clk(clk), .reset(reset), .flush(flush), .ready_in(rdy8), .valid_in(valid_in),
    .data_in(data_in), .ready_out(ready_out), .valid_out(v8), .data_out(d8), .count(c8)
  );

  fifo_w1rn #(.WIDTH(8), .DEPTH(5), .NUM_RD(NRD)) u_dut5 (
    .clk(clk), .reset(reset), .flush(flush), .ready_in(rdy5), .valid_in(valid_in),
    .data_in(data_in), .ready_out(ready_out), .valid_out(v5), .data_out(d5), .count(c5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // The FIFO as one ordered list: lanes show its first NRD entries; a pop
  // removes the chosen visible entries; a write appends when below capacity.
  function automatic byteq_t model_next(byteq_t q, int cap, logic rst, logic fl,
                                        logic vin, logic [7:0] din, logic [NRD-1:0] rdy);
    byteq_t r;
    int sz;
    sz = q.size();
    if (rst || fl) return r;
    for (int i = 0; i < sz; i++) begin
      if (!(i < NRD && rdy[i])) r.push_back(q[i]);
    end
    if (vin && sz < cap) r.push_back(din);
    return r;
  endfunction

  task automatic compare_all();
    for (int i = 0; i < NRD; i++) begin
      check($sformatf("d8 valid[%0d]", i), 32'(v8[i]), 32'(i < q8.size()));
      if (i < q8.size()) check($sformatf("d8 data[%0d]", i), 32'(d8[i]), 32'(q8[i]));
      check($sformatf("d5 valid[%0d]", i), 32'(v5[i]), 32'(i < q5.size()));
      if (i < q5.size()) check($sformatf("d5 data[%0d]", i), 32'(d5[i]), 32'(q5[i]));
    end
    check("d8 count", 32'(c8), 32'(q8.size()));
    check("d5 count", 32'(c5), 32'(q5.size()));
    check("d8 ready_in", 32'(rdy8), 32'(q8.size() < CAP8));
    check("d5 ready_in", 32'(rdy5), 32'(q5.size() < CAP5));
  endtask

  task automatic step();
    @(posedge clk);
    q8 = model_next(q8, CAP8, reset, flush, valid_in, data_in, ready_out);
    q5 = model_next(q5, CAP5, reset, flush, valid_in, data_in, ready_out);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic rst, input logic fl, input logic vin,
                       input logic [7:0] din, input logic [NRD-1:0] rdy);
    reset = rst; flush = fl; valid_in = vin; data_in = din; ready_out = rdy;
    step();
  endtask

  initial begin
    bit seen [256];
    int next_wr, popped, dups, cyc;
    logic acc;

    // Reset state, including zeroed lane data.
    drive(1, 0, 0, 8'h00, '0);
    drive(1, 0, 0, 8'h00, '0);
    for (int i = 0; i < NRD; i++) check($sformatf("reset data[%0d]", i), 32'(d8[i]), 32'h0);

    // Bypass writes into empty lanes.
    drive(0, 0, 1, 8'h11, '0);
    check("bypass first lane", 32'(d8[0]), 32'h11);
    drive(0, 0, 1, 8'h22, '0);
    drive(0, 0, 1, 8'h33, '0);
    check("bypass count", 32'(c8), 32'd3);
    check("bypass lane2", 32'(d8[2]), 32'h33);

    // Fill to capacity, then one refused write.
    drive(0, 1, 0, 8'h00, '0);
    for (int i = 1; i <= 12; i++) drive(0, 0, 1, 8'(i), '0);
    check("full ready_in", 32'(rdy8), 32'd0);
    check("full count", 32'(c8), 32'd12);
    drive(0, 0, 1, 8'h0D, '0);
    check("refused count", 32'(c8), 32'd12);

    // Sparse pop 0101 from full.
    drive(0, 0, 0, 8'h00, 4'b0101);
    check("sparse lane0", 32'(d8[0]), 32'h02);
    check("sparse lane1", 32'(d8[1]), 32'h04);
    check("sparse lane3", 32'(d8[3]), 32'h06);
    check("sparse count", 32'(c8), 32'd10);

    // Write while memory full is refused even though lanes drain.
    drive(0, 0, 1, 8'h0D, '0);
    drive(0, 0, 1, 8'h0E, '0);
    drive(0, 0, 1, 8'hEE, 4'b1111);
    check("full rd+wr count", 32'(c8), 32'd8);

    // Flush with a concurrent write and read.
    drive(1, 0, 0, 8'h00, '0);
    for (int i = 0; i < 6; i++) drive(0, 0, 1, 8'(8'h60 + i), '0);
    drive(0, 1, 1, 8'h77, 4'b0001);
    check("flush valid_out", 32'(v8), 32'h0);
    check("flush count", 32'(c8), 32'd0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 8'h00, '0);

    // Stream 40 ascending words through DEPTH 5 with random pops.
    drive(1, 0, 0, 8'h00, '0);
    reset = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    next_wr = 0; popped = 0; dups = 0; cyc = 0;
    while ((next_wr < 40 || q5.size() > 0) && cyc < 2000) begin
      valid_in  = (next_wr < 40) && ($urandom_range(0, 3) != 0);
      data_in   = 8'(next_wr);
      ready_out = NRD'($urandom);
      for (int i = 0; i < NRD; i++) begin
        if (ready_out[i] && v5[i]) begin
          if (seen[d5[i]]) dups++;
          seen[d5[i]] = 1'b1;
          popped++;
        end
      end
      acc = valid_in && rdy5;
      step();
      if (acc) next_wr++;
      cyc++;
    end
    check("stream written", 32'(next_wr), 32'd40);
    check("stream popped", 32'(popped), 32'd40);
    check("stream duplicates", 32'(dups), 32'd0);

    // Fully random traffic with occasional flush.
    for (int n = 0; n < 300; n++)
      drive(0, ($urandom_range(0, 19) == 0), 1'($urandom), 8'($urandom), NRD'($urandom));

    // Reset mid-stream with nine entries held.
    drive(1, 0, 0, 8'h00, '0);
    for (int i = 0; i < 9; i++) drive(0, 0, 1, 8'(8'hA0 + i), '0);
    check("pre-reset count", 32'(c8), 32'd9);
    drive(1, 0, 1, 8'h55, 4'b0011);
    check("mid reset valid_out", 32'(v8), 32'h0);
    check("mid reset count", 32'(c8), 32'd0);
    check("mid reset ready_in", 32'(rdy8), 32'd1);
    for (int i = 0; i < NRD; i++) check($sformatf("mid reset data[%0d]", i), 32'(d8[i]), 32'h0);
    drive(0, 0, 1, 8'hAA, '0);
    check("post reset lane0 valid", 32'(v8[0]), 32'd1);
    check("post reset lane0 data", 32'(d8[0]), 32'hAA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_w1rn.md
Name: fifo_w1rn

Overview:
- Synchronous FIFO with one write port and NUM_RD parallel read lanes.
- Lane 0 always presents the oldest entry. The consumer may pop any subset of valid lanes per cycle; survivors compact toward lane 0 in order.
- Successor to the fixed 4-lane FIFO, adding:
  - parametrised lane count;
  - full use of DEPTH, including non-power-of-2 depths;
  - write bypass into empty lanes;
  - occupancy output;
  - synchronous flush.
- Used in front of multi-issue consumers.

Parameters:
- WIDTH, 8, data word width.
- DEPTH, 8, backing memory entries; >=2; any integer.
- NUM_RD, 4, read lanes; >=1.
- CNT_W, $clog2(DEPTH+NUM_RD+1), occupancy width (derived localparam).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  synchronous clear of all contents
- ready_in  out  1  write may be accepted
- valid_in  in  1  write request
- data_in  in  WIDTH  write data
- ready_out  in  NUM_RD  per-lane consume
- valid_out  out  NUM_RD  per-lane valid (registered)
- data_out  out  WIDTH x NUM_RD (unpacked [NUM_RD-1:0])  per-lane data (registered)
- count  out  CNT_W  total entries held (memory + valid lanes)

Behaviour:
- Reset: valid_out=0, data_out=0, count=0, ready_in=1; memory pointers and memory count = 0; memory array contents not reset.
- Total capacity = DEPTH + NUM_RD.
- Lane invariant: valid lanes are always contiguous from lane 0. Lane i valid implies lanes 0..i-1 valid.
- Handshakes:
  - Read on lane i = valid_out[i] & ready_out[i].
  - ready_out on an invalid lane is ignored.
  - Write = valid_in & ready_in.
- ready_in = (mem_count < DEPTH). It is a function of registered state only; there is no combinational path from ready_out or valid_in.
- Per clock edge, evaluated in this order:
  - (a) Surviving (unread) valid lanes shift down to the lowest indices, preserving relative order.
  - (b) Vacant lanes fill in order from the memory head, up to min(vacant, mem_count) entries; rd_ptr advances by that amount.
  - (c) If a vacant lane still remains after (b), the write data goes directly into the next vacant lane (bypass). Otherwise it goes to mem[wr_ptr] and wr_ptr advances.
- Latency: a write into an empty FIFO is visible on valid_out[0] one cycle after acceptance. Data never overtakes older data.
- Pointers wrap from DEPTH-1 to 0 by explicit compare, not modulo-2^n. mem_count ranges 0..DEPTH.
- Simultaneous write + read with memory full: ready_in=0, so the write is refused even though lanes free up.
- count updates every edge to the exact post-edge total: count_next = count + write - popcount(read).
- Flush:
  - Takes priority over reads and writes in the same cycle.
  - Next cycle: all lanes invalid, pointers 0, mem_count 0, count 0.
  - A write handshaked in the flush cycle is discarded; reads in the flush cycle still count as consumed by the sink.
- Reset has priority over flush. Reset mid-operation discards everything; data_out returns to 0.
- No underflow or overflow is possible by construction. An assertion is required that count <= DEPTH+NUM_RD and that the lane invariant holds.

Decomposition:
- Package fifo_pkg: function popcount_nrd (read-mask population count) and the CNT_W derivation helper.
- One natural sub-module: fifo_lane_compact. It is combinational; inputs are lane valid/data and the read mask, outputs are compacted lanes and the survivor count. It is instantiated once and reused by future multi-read blocks.
- The top level holds the memory, pointers, fill/bypass logic, count and flush.

Test Plan:
- Reset, then write 0x11,0x22,0x33 on consecutive cycles with ready_out=0 -> lanes 0..2 hold 0x11,0x22,0x33 at cycles 1..3 via bypass; count=3; mem_count=0.
- Fill with 0x01..0x0C (DEPTH=8, NUM_RD=4), no reads -> ready_in drops after the 12th accept; count=12; lanes 0x01..0x04.
- From the full state, ready_out=4'b0101 -> next cycle lanes = 0x02,0x04,0x05,0x06; count=10; ready_in=1.
- DEPTH=5, stream 40 words with random ready_out -> output order strictly 0..39; pointer wrap at 4->0 observed; no loss or duplication.
- Hold 6 entries; assert flush together with valid_in=1 and ready_out=4'b0001 -> next cycle valid_out=0, count=0, the written word is never output.
- Assert reset while count=9 mid-stream -> next cycle valid_out=0, data_out=0, count=0, ready_in=1; subsequent write 0xAA appears on lane 0 one cycle later.
